uart_tx_arbiter: RTL and testbench

- Round-robin packet arbiter that shares the UART transmit path (TX FIFO write port: w_data / w_uart / tx_full) between NREQ independent requesters.
- Each granted requester sends one packet: a header byte {requester id, length} followed by LEN payload bytes, with a valid/ready handshake per byte.
- Sits between client logic and the UART top-level TX FIFO write interface.
- The grant is held for a whole packet, so bytes from different requesters never interleave.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin packet arbiter sharing one UART TX FIFO write port
//             between NREQ requesters. A granted requester sends a header
//             byte {id, len} followed by len payload bytes. The grant is held
//             for the whole packet, so packets never interleave.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             req/req_len      - per-requester packet request and length
//             req_data/valid   - per-requester payload byte and valid
//             req_ready        - per-requester byte accepted (granted only)
//             grant/busy       - one-hot grant, packet in progress
//             pkt_done         - one-cycle pulse after the last byte
//             w_data/w_uart    - TX FIFO write data / write enable
//             tx_full          - TX FIFO full
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DBIT  = 8,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*DBIT-1:0]  req_data,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  pkt_done,
    output logic [DBIT-1:0]       w_data,
    output logic                  w_uart,
    input  logic                  tx_full
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ID_W-1:0] c_LAST_INIT = ID_W'(NREQ - 1);

    state_t             state_q,  state_d;
    logic [NREQ-1:0]    grant_q,  grant_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [LEN_W-1:0]   cnt_q,    cnt_d;
    logic [ID_W-1:0]    last_q,   last_d;

    logic               w_any;
    logic [ID_W-1:0]    w_sel;
    logic [ID_W-1:0]    w_idx;
    logic               w_wr;
    logic [NREQ-1:0]    w_rdy;

    // Round-robin search starting at last+1. Offsets are scanned from the
    // farthest to the nearest so the nearest set request is the one that
    // remains selected. NREQ is a power of two, so the ID_W-bit add wraps
    // modulo NREQ by itself.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = last_q + ID_W'(k);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cur_id_d = cur_id_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        w_wr     = 1'b0;
        w_data   = '0;
        w_rdy    = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    grant_d  = NREQ'(1) << w_sel;
                    cur_id_d = w_sel;
                    cnt_d    = req_len[w_sel*LEN_W +: LEN_W];
                    last_d   = w_sel;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                w_data = {cur_id_q, cnt_q};
                if (!tx_full) begin
                    w_wr    = 1'b1;
                    state_d = (cnt_q == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                w_rdy[cur_id_q] = !tx_full;
                w_data          = req_data[cur_id_q*DBIT +: DBIT];
                if (req_valid[cur_id_q] && !tx_full) begin
                    w_wr  = 1'b1;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // A reset that lands mid-packet must not let one more byte slip into
    // the FIFO during the reset cycle, so the write strobes are gated.
    assign w_uart    = w_wr & ~reset;
    assign req_ready = w_rdy & {NREQ{~reset}};

    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_done = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            cur_id_q <= '0;
            cnt_q    <= '0;
            last_q   <= c_LAST_INIT;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cur_id_q <= cur_id_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. Expected FIFO writes
//             ({grant, byte}) are queued when a request is issued and popped
//             as the DUT writes. Requesters are modelled by payload queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int DBIT  = 8;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int LEN_W = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*DBIT-1:0]  req_data;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  pkt_done;
    logic [DBIT-1:0]       w_data;
    logic                  w_uart;
    logic                  tx_full;

    uart_tx_arbiter #(.DBIT(DBIT), .NREQ(NREQ), .ID_W(ID_W), .LEN_W(LEN_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .w_data    (w_data),
        .w_uart    (w_uart),
        .tx_full   (tx_full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [NREQ+DBIT-1:0] sb [$];
    logic [DBIT-1:0]      pld [NREQ][$];
    logic [NREQ-1:0]      hold;
    logic [NREQ-1:0]      gap;
    logic                 phase;

    logic                 s_busy, s_wuart, s_done;
    logic [NREQ-1:0]      s_grant, s_rdy;
    logic                 prev_w, in_pkt, rdy_seen;
    int                   cyc, t_first, t_done, done_cnt, pw_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DBIT +: DBIT] = (pld[i].size() > 0) ? pld[i][0] : '0;
            req_valid[i] = (pld[i].size() > 0) && (!gap[i] || phase);
        end
    endtask

    // One clock cycle: monitor at negedge, requester model updates after posedge.
    task automatic step();
        logic [NREQ-1:0]      xfer;
        logic [NREQ+DBIT-1:0] exp_w;
        @(negedge clk);
        s_busy  = busy;
        s_grant = grant;
        s_wuart = w_uart;
        s_rdy   = req_ready;
        s_done  = pkt_done;
        xfer    = req_ready & req_valid;
        rdy_seen = rdy_seen | (|req_ready);
        if ((req_ready & ~grant) != '0)
            chk("ready_not_granted", int'(req_ready), int'(req_ready & grant));
        if (w_uart && tx_full)
            chk("write_while_full", 1, 0);
        if (w_uart) begin
            if (|req_ready) begin
                pw_cnt++;
                chk("valid_on_payload_wr", int'(|(req_valid & grant)), 1);
            end
            if (!in_pkt) begin
                in_pkt  = 1'b1;
                t_first = cyc;
            end
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                exp_w = sb.pop_front();
                chk("fifo_write", int'({grant, w_data}), int'(exp_w));
            end
        end
        if (pkt_done) begin
            chk("done_after_last_wr", int'(prev_w), 1);
            done_cnt++;
            t_done = cyc;
            in_pkt = 1'b0;
        end
        prev_w = w_uart;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if (xfer[i] && pld[i].size() > 0) void'(pld[i].pop_front());
        // Requesters drop req during the DONE cycle unless told to hold it.
        if (pkt_done)
            for (int i = 0; i < NREQ; i++)
                if (grant[i] && !hold[i]) req[i] = 1'b0;
        phase = ~phase;
        drive_reqs();
    endtask

    task automatic request(input int id, input int len, input logic [7:0] base,
                           input logic [7:0] inc);
        logic [NREQ-1:0] oh;
        logic [7:0]      b;
        oh = NREQ'(1) << id;
        req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
        sb.push_back({oh, ID_W'(id), LEN_W'(len)});
        for (int k = 0; k < len; k++) begin
            b = base + 8'(k) * inc;
            pld[id].push_back(b);
            sb.push_back({oh, b});
        end
        req[id] = 1'b1;
        drive_reqs();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(sb.size() == 0 && !s_busy) && n < max_cyc);
        if (!(sb.size() == 0 && !s_busy))
            chk("idle_timeout_pending", sb.size(), 0);
    endtask

    initial begin
        reset = 1'b1; req = '0; req_len = '0; req_data = '0; req_valid = '0;
        tx_full = 1'b0; hold = '0; gap = '0; phase = 1'b0;
        prev_w = 1'b0; in_pkt = 1'b0; rdy_seen = 1'b0;
        cyc = 0; t_first = 0; t_done = 0; done_cnt = 0; pw_cnt = 0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy",     int'(s_busy),  0);
        chk("rst_grant",    int'(s_grant), 0);
        chk("rst_w_uart",   int'(s_wuart), 0);
        chk("rst_ready",    int'(s_rdy),   0);
        chk("rst_pkt_done", int'(s_done),  0);

        // Round robin from reset: req0 and req2 held, len=1 each.
        req_len[0*LEN_W +: LEN_W] = 6'd1;
        req_len[2*LEN_W +: LEN_W] = 6'd1;
        hold = 4'b0101;
        pld[0].push_back(8'hA1); pld[0].push_back(8'hA3);
        pld[2].push_back(8'hA2); pld[2].push_back(8'hA4);
        sb.push_back({4'b0001, 8'h01}); sb.push_back({4'b0001, 8'hA1});
        sb.push_back({4'b0100, 8'h81}); sb.push_back({4'b0100, 8'hA2});
        sb.push_back({4'b0001, 8'h01}); sb.push_back({4'b0001, 8'hA3});
        sb.push_back({4'b0100, 8'h81}); sb.push_back({4'b0100, 8'hA4});
        req = 4'b0101;
        drive_reqs();
        done_cnt = 0;
        for (int n = 0; n < 100 && done_cnt < 3; n++) step();
        hold = '0;
        req[0] = 1'b0;
        run_until_idle(100);
        chk("rr_packets", done_cnt, 4);

        // Single packet: req2, payload 11,22,33.
        request(2, 3, 8'h11, 8'h11);
        run_until_idle(50);
        chk("single_hdr_to_done", t_done - t_first, 4);

        // Backpressure: 5 full cycles after the first payload byte.
        request(3, 4, 8'hC0, 8'h01);
        for (int n = 0; n < 50 && sb.size() > 3; n++) step();
        chk("bp_progress", sb.size(), 3);
        tx_full = 1'b1;
        repeat (5) begin
            step();
            chk("bp_w_uart", int'(s_wuart), 0);
            chk("bp_ready",  int'(s_rdy),   0);
        end
        tx_full = 1'b0;
        run_until_idle(50);

        // Zero length: header only, never ready.
        rdy_seen = 1'b0;
        request(1, 0, 8'h00, 8'h01);
        run_until_idle(50);
        chk("zero_len_ready", int'(rdy_seen), 0);

        // Valid gaps on a len=2 packet.
        gap = 4'b0100;
        pw_cnt = 0;
        request(2, 2, 8'hB0, 8'h01);
        run_until_idle(50);
        chk("gap_payload_writes", pw_cnt, 2);
        gap = '0;

        // Reset mid-packet after the first of five payload bytes.
        request(0, 5, 8'hD0, 8'h01);
        for (int n = 0; n < 50 && sb.size() > 4; n++) step();
        chk("rstmid_progress", sb.size(), 4);
        req[0] = 1'b0;
        pld[0].delete();
        sb.delete();
        reset = 1'b1;
        drive_reqs();
        step();
        reset = 1'b0;
        in_pkt = 1'b0;
        step();
        chk("rstmid_busy",   int'(s_busy),  0);
        chk("rstmid_grant",  int'(s_grant), 0);
        chk("rstmid_w_uart", int'(s_wuart), 0);
        request(0, 1, 8'hE0, 8'h01);
        run_until_idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
